// File: rtl/sipo_frame_ctrl_if.sv
// Bus between the framed serial source, the SIPO frame controller and the parallel consumer.
// The slave modport is the controller's view; the master modport is the source/consumer view.
interface sipo_frame_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
);
    logic             start_i;
    logic             abort_i;
    logic [LEN_W-1:0] frame_len_i;
    logic             sin_i;
    logic             sin_valid_i;
    logic [WIDTH-1:0] pout_o;
    logic             pout_valid_o;
    logic             pout_ready_i;
    logic             busy_o;
    logic             frame_done_o;
    logic             overrun_o;
    logic [7:0]       ovr_cnt_o;

    modport slave (
        input  start_i, abort_i, frame_len_i, sin_i, sin_valid_i, pout_ready_i,
        output pout_o, pout_valid_o, busy_o, frame_done_o, overrun_o, ovr_cnt_o
    );

    modport master (
        output start_i, abort_i, frame_len_i, sin_i, sin_valid_i, pout_ready_i,
        input  pout_o, pout_valid_o, busy_o, frame_done_o, overrun_o, ovr_cnt_o
    );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// SIPO frame controller: assembles serial bits into WIDTH-bit words, hands them out through a
// single-entry valid/ready output register, counts words per frame and reports drops.
module sipo_frame_ctrl #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1,
    parameter int LEN_W     = 8
) (
    input  logic              clk,
    input  logic              arst_n,
    sipo_frame_ctrl_if.slave  bus
);
    localparam int BCW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0]   BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [BCW-1:0]   BIT_ONE  = BCW'(1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [BCW-1:0]   bit_cnt_q;
    logic [LEN_W-1:0] word_cnt_q;
    logic [LEN_W-1:0] len_q;
    logic [WIDTH-1:0] pout_q;
    logic             pout_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             ovr_q;
    logic [7:0]       ovr_cnt_q;

    logic [WIDTH-1:0] sreg_d;
    logic             out_free_s;
    logic             take_s;

    // Next shift-register contents with the current serial bit folded in.
    always_comb begin
        if (LSB_FIRST != 0) begin
            sreg_d = {bus.sin_i, sreg_q[WIDTH-1:1]};
        end else begin
            sreg_d = {sreg_q[WIDTH-2:0], bus.sin_i};
        end
    end

    assign take_s     = pout_valid_q & bus.pout_ready_i;
    assign out_free_s = ~pout_valid_q | bus.pout_ready_i;

    // Frame sequencer with all outputs registered.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= ST_IDLE;
            sreg_q       <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            len_q        <= '0;
            pout_q       <= '0;
            pout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovr_q        <= 1'b0;
            ovr_cnt_q    <= 8'd0;
        end else begin
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
            // A taken word frees the output register; a same-edge load below overrides this.
            if (take_s) begin
                pout_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i && !bus.abort_i) begin
                        len_q      <= bus.frame_len_i;
                        bit_cnt_q  <= '0;
                        word_cnt_q <= '0;
                        if (bus.frame_len_i == LEN_ZERO) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ST_SHIFT;
                            busy_q  <= 1'b1;
                        end
                    end
                end

                ST_SHIFT: begin
                    if (bus.abort_i) begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        bit_cnt_q  <= '0;
                        word_cnt_q <= '0;
                    end else if (bus.sin_valid_i) begin
                        sreg_q <= sreg_d;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q  <= '0;
                            word_cnt_q <= word_cnt_q + LEN_ONE;
                            if (out_free_s) begin
                                pout_q       <= sreg_d;
                                pout_valid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                                if (ovr_cnt_q != 8'hFF) begin
                                    ovr_cnt_q <= ovr_cnt_q + 8'd1;
                                end
                            end
                            if ((word_cnt_q + LEN_ONE) == len_q) begin
                                state_q <= ST_DRAIN;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_ONE;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (bus.abort_i) begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        bit_cnt_q  <= '0;
                        word_cnt_q <= '0;
                    end else if (out_free_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pout_o       = pout_q;
    assign bus.pout_valid_o = pout_valid_q;
    assign bus.busy_o       = busy_q;
    assign bus.frame_done_o = done_q;
    assign bus.overrun_o    = ovr_q;
    assign bus.ovr_cnt_o    = ovr_cnt_q;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl: an LSB-first instance is checked throughout, and an
// MSB-first twin fed the same stimulus is checked for bit ordering.
module tb_sipo_frame_ctrl;
    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    int   total  = 0;
    int   bad    = 0;
    int   cyc    = 0;
    int   t0     = 0;

    sipo_frame_ctrl_if #(.WIDTH(8), .LEN_W(8)) ba ();
    sipo_frame_ctrl_if #(.WIDTH(8), .LEN_W(8)) bm ();

    assign bm.start_i      = ba.start_i;
    assign bm.abort_i      = ba.abort_i;
    assign bm.frame_len_i  = ba.frame_len_i;
    assign bm.sin_i        = ba.sin_i;
    assign bm.sin_valid_i  = ba.sin_valid_i;
    assign bm.pout_ready_i = ba.pout_ready_i;

    sipo_frame_ctrl #(.WIDTH(8), .LSB_FIRST(1), .LEN_W(8)) dut (
        .clk(clk), .arst_n(arst_n), .bus(ba)
    );
    sipo_frame_ctrl #(.WIDTH(8), .LSB_FIRST(0), .LEN_W(8)) dut_msb (
        .clk(clk), .arst_n(arst_n), .bus(bm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serial order: w[0] is sent first. Optional gap of gap_n idle cycles after bit index gap_at.
    task automatic send(input logic [7:0] w, input int gap_at, input int gap_n, input bit early);
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            ba.sin_valid_i = 1'b1;
            ba.sin_i       = w[i];
            if (early && i == 7) check("early_valid", {31'd0, ba.pout_valid_o}, 32'd0);
            tick();
            if (i == gap_at) begin
                ba.sin_valid_i = 1'b0;
                repeat (gap_n) tick();
            end
        end
        ba.sin_valid_i = 1'b0;
    endtask

    task automatic start_frame(input logic [7:0] len);
        ba.start_i     = 1'b1;
        ba.frame_len_i = len;
        tick();
        ba.start_i     = 1'b0;
    endtask

    initial begin
        ba.start_i = 1'b0; ba.abort_i = 1'b0; ba.frame_len_i = 8'd0;
        ba.sin_i = 1'b0; ba.sin_valid_i = 1'b0; ba.pout_ready_i = 1'b1;

        repeat (2) tick();
        check("rst_valid", {31'd0, ba.pout_valid_o}, 32'd0);
        check("rst_pout",  {24'd0, ba.pout_o}, 32'd0);
        check("rst_busy",  {31'd0, ba.busy_o}, 32'd0);
        check("rst_done",  {31'd0, ba.frame_done_o}, 32'd0);
        check("rst_ovr",   {31'd0, ba.overrun_o}, 32'd0);
        check("rst_ovrcnt", {24'd0, ba.ovr_cnt_o}, 32'd0);
        arst_n = 1'b1;
        tick();

        // 1: single word, ready high
        start_frame(8'd1);
        check("t1_busy", {31'd0, ba.busy_o}, 32'd1);
        send(8'h4D, -1, 0, 1'b1);
        check("t1_pout",  {24'd0, ba.pout_o}, 32'h4D);
        check("t1_valid", {31'd0, ba.pout_valid_o}, 32'd1);
        check("t1_lat",   cyc - t0, 32'd8);
        check("t1_nodone", {31'd0, ba.frame_done_o}, 32'd0);
        tick();
        check("t1_done",   {31'd0, ba.frame_done_o}, 32'd1);
        check("t1_idle",   {31'd0, ba.busy_o}, 32'd0);
        check("t1_taken",  {31'd0, ba.pout_valid_o}, 32'd0);
        tick();
        check("t1_done_pulse", {31'd0, ba.frame_done_o}, 32'd0);

        // 2: gap of 3 idle cycles after bit 4, plus MSB-first ordering
        start_frame(8'd1);
        send(8'h4D, 3, 3, 1'b1);
        check("t2_pout",  {24'd0, ba.pout_o}, 32'h4D);
        check("t2_valid", {31'd0, ba.pout_valid_o}, 32'd1);
        check("t2_lat",   cyc - t0, 32'd11);
        check("t2_msb_pout",  {24'd0, bm.pout_o}, 32'hB2);
        check("t2_msb_valid", {31'd0, bm.pout_valid_o}, 32'd1);
        tick();
        check("t2_done", {31'd0, ba.frame_done_o}, 32'd1);
        tick();

        // 3: two words, ready low -> second word dropped, wait in DRAIN
        ba.pout_ready_i = 1'b0;
        start_frame(8'd2);
        send(8'h4D, -1, 0, 1'b1);
        check("t3_w1_pout",  {24'd0, ba.pout_o}, 32'h4D);
        check("t3_w1_valid", {31'd0, ba.pout_valid_o}, 32'd1);
        check("t3_w1_noovr", {31'd0, ba.overrun_o}, 32'd0);
        send(8'hFF, -1, 0, 1'b0);
        check("t3_ovr",    {31'd0, ba.overrun_o}, 32'd1);
        check("t3_ovrcnt", {24'd0, ba.ovr_cnt_o}, 32'd1);
        check("t3_hold",   {24'd0, ba.pout_o}, 32'h4D);
        tick();
        check("t3_ovr_pulse", {31'd0, ba.overrun_o}, 32'd0);
        tick();
        check("t3_drain_busy", {31'd0, ba.busy_o}, 32'd1);
        check("t3_drain_nodone", {31'd0, ba.frame_done_o}, 32'd0);
        check("t3_drain_hold", {24'd0, ba.pout_o}, 32'h4D);
        ba.pout_ready_i = 1'b1;
        tick();
        ba.pout_ready_i = 1'b0;
        check("t3_done",  {31'd0, ba.frame_done_o}, 32'd1);
        check("t3_taken", {31'd0, ba.pout_valid_o}, 32'd0);
        check("t3_idle",  {31'd0, ba.busy_o}, 32'd0);
        tick();

        // 4: abort mid-word 2, then a clean new frame
        start_frame(8'd3);
        send(8'hA5, -1, 0, 1'b1);
        check("t4_w1", {24'd0, ba.pout_o}, 32'hA5);
        for (int i = 0; i < 5; i++) begin
            ba.sin_valid_i = 1'b1; ba.sin_i = 1'b1;
            tick();
        end
        ba.sin_valid_i = 1'b0;
        ba.abort_i = 1'b1;
        tick();
        ba.abort_i = 1'b0;
        check("t4_abort_idle",   {31'd0, ba.busy_o}, 32'd0);
        check("t4_abort_nodone", {31'd0, ba.frame_done_o}, 32'd0);
        check("t4_abort_valid",  {31'd0, ba.pout_valid_o}, 32'd1);
        check("t4_abort_pout",   {24'd0, ba.pout_o}, 32'hA5);
        tick();
        check("t4_abort_nodone2", {31'd0, ba.frame_done_o}, 32'd0);
        ba.pout_ready_i = 1'b1;
        start_frame(8'd1);
        send(8'h3C, -1, 0, 1'b1);
        check("t4_new_pout", {24'd0, ba.pout_o}, 32'h3C);
        check("t4_new_valid", {31'd0, ba.pout_valid_o}, 32'd1);
        tick();
        check("t4_new_done", {31'd0, ba.frame_done_o}, 32'd1);
        tick();

        // abort in IDLE overrides start (len 0 would otherwise pulse frame_done)
        ba.start_i = 1'b1; ba.abort_i = 1'b1; ba.frame_len_i = 8'd0;
        tick();
        ba.start_i = 1'b0; ba.abort_i = 1'b0;
        check("idle_abort_nodone", {31'd0, ba.frame_done_o}, 32'd0);
        check("idle_abort_busy",   {31'd0, ba.busy_o}, 32'd0);
        tick();

        // 5: asynchronous reset mid-SHIFT with a pending word
        ba.pout_ready_i = 1'b0;
        start_frame(8'd2);
        send(8'h12, -1, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            ba.sin_valid_i = 1'b1; ba.sin_i = 1'b0;
            tick();
        end
        ba.sin_valid_i = 1'b0;
        check("t5_pre_valid", {31'd0, ba.pout_valid_o}, 32'd1);
        #2;
        arst_n = 1'b0;
        #1;
        check("t5_rst_valid",  {31'd0, ba.pout_valid_o}, 32'd0);
        check("t5_rst_pout",   {24'd0, ba.pout_o}, 32'd0);
        check("t5_rst_busy",   {31'd0, ba.busy_o}, 32'd0);
        check("t5_rst_ovrcnt", {24'd0, ba.ovr_cnt_o}, 32'd0);
        repeat (2) tick();
        arst_n = 1'b1;
        ba.pout_ready_i = 1'b1;
        start_frame(8'd1);
        check("t5_busy", {31'd0, ba.busy_o}, 32'd1);
        send(8'h81, -1, 0, 1'b1);
        check("t5_pout", {24'd0, ba.pout_o}, 32'h81);
        tick();
        check("t5_done", {31'd0, ba.frame_done_o}, 32'd1);
        tick();

        // 6: zero-length frame
        start_frame(8'd0);
        check("t6_done",  {31'd0, ba.frame_done_o}, 32'd1);
        check("t6_busy",  {31'd0, ba.busy_o}, 32'd0);
        check("t6_valid", {31'd0, ba.pout_valid_o}, 32'd0);
        tick();
        check("t6_done_pulse", {31'd0, ba.frame_done_o}, 32'd0);
        check("t6_busy2", {31'd0, ba.busy_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
